mux_scan_sequencer: RTL and testbench

Sequencing stage wrapped around the 4:1 data mux.
- Upstream role: drives the mux `sel` through channels 0→1→2→3, holding each for a programmable dwell time.
- Downstream role: consumes the mux `out` and registers one sample per channel.
- Assembles a 4-channel frame that updates atomically and flags each completed frame.
- A manual mode pins `sel` for single-channel observation.

---
 rtl/mux_scan_sequencer_pkg.sv | 27 ++
 rtl/mux_scan_sequencer_if.sv | 40 ++++
 rtl/mux_scan_sequencer_dwell_counter.sv | 40 ++++
 rtl/mux_scan_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the mux scan sequencer slice.
//   state_t    : sequencer FSM states (IDLE, SCAN, MAN)
//   N_CH       : number of mux channels in one frame
//   SEL_W      : width of the mux select
//   cnt_width  : dwell counter width for a given dwell length (minimum 1)
// ---------------------------------------------------------------------------
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    MAN  = 2'd2
  } state_t;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  // A dwell of one cycle still needs a one-bit counter so that the
  // terminal compare has something to look at.
  function automatic int cnt_width(input int dwell);
    if (dwell <= 1) return 1;
    return $clog2(dwell);
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer_if
// Bundles the control inputs, the mux loop (sel out / mux_out in) and the
// sample/frame outputs of the sequencer.
//   en, manual, man_sel : scan control
//   mux_out             : combinational mux output, function of sel
//   sel                 : registered mux select
//   sample_data/ch/valid: per-capture result and one-cycle pulse
//   frame/frame_done    : {ch3,ch2,ch1,ch0} and its update pulse
//   busy                : sequencer is in SCAN or MAN
// master = sequencer side, slave = environment (controller + mux) side.
// ---------------------------------------------------------------------------
interface mux_scan_sequencer_if #(
  parameter int DATA_WIDTH = 4
);
  import mux_scan_pkg::*;

  logic                       en;
  logic                       manual;
  logic [SEL_W-1:0]           man_sel;
  logic [DATA_WIDTH-1:0]      mux_out;
  logic [SEL_W-1:0]           sel;
  logic [DATA_WIDTH-1:0]      sample_data;
  logic [SEL_W-1:0]           sample_ch;
  logic                       sample_valid;
  logic [N_CH*DATA_WIDTH-1:0] frame;
  logic                       frame_done;
  logic                       busy;

  modport master (
    input  en, manual, man_sel, mux_out,
    output sel, sample_data, sample_ch, sample_valid, frame, frame_done, busy
  );

  modport slave (
    output en, manual, man_sel, mux_out,
    input  sel, sample_data, sample_ch, sample_valid, frame, frame_done, busy
  );

endinterface

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// ---------------------------------------------------------------------------
// scan_dwell_counter
// Counts the cycles a mux channel has been held and flags the last one.
//   clk, rst   : clock, async active-high reset
//   i_clear    : force the count to 0 (wins over i_tick)
//   i_tick     : advance; wraps to 0 when already at DWELL-1
//   o_terminal : count equals DWELL-1 (the capture cycle)
// ---------------------------------------------------------------------------
module scan_dwell_counter
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_terminal
);

  localparam int             CNT_W = cnt_width(DWELL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_count;

  assign o_terminal = (r_count == LAST);

  // The count never passes LAST: a tick on the terminal cycle wraps it
  // straight back to zero, so no overflow handling is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= o_terminal ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
// Walks the 4:1 mux select through channels 0..3, holding each for DWELL
// cycles, captures one sample per channel on the last dwell cycle and
// publishes a complete 4-channel frame atomically. Manual mode pins the
// select to man_sel and keeps sampling without building frames.
//   clk, rst : clock, async active-high reset
//   bus      : mux_scan_sequencer_if.master (control, mux loop, results)
// ---------------------------------------------------------------------------
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int DWELL      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mux_scan_sequencer_if.master   bus
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t                     r_state;
  state_t                     w_stateNext;
  logic [SEL_W-1:0]           r_sel;
  logic [SEL_W-1:0]           w_selNext;
  logic [DATA_WIDTH-1:0]      r_sampleData;
  logic [DATA_WIDTH-1:0]      w_sampleDataNext;
  logic [SEL_W-1:0]           r_sampleCh;
  logic [SEL_W-1:0]           w_sampleChNext;
  logic                       r_sampleValid;
  logic                       w_sampleValidNext;
  logic [N_CH*DATA_WIDTH-1:0] r_frame;
  logic [N_CH*DATA_WIDTH-1:0] w_frameNext;
  logic                       r_frameDone;
  logic                       w_frameDoneNext;
  logic [DATA_WIDTH-1:0]      r_shadow [N_CH-1];
  logic                       w_shadowWe;
  logic                       w_shadowClear;
  logic                       w_cntClear;
  logic                       w_cntTick;
  logic                       w_terminal;

  scan_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_cntClear),
    .i_tick     (w_cntTick),
    .o_terminal (w_terminal)
  );

  // Next-state and next-output logic. Everything defaults to "hold" with
  // the pulses low, so only captures raise sample_valid/frame_done.
  // Channel 3 goes straight into the frame from mux_out; channels 0..2
  // come from the shadow registers filled earlier in the same frame.
  always_comb begin
    w_stateNext       = r_state;
    w_selNext         = r_sel;
    w_sampleDataNext  = r_sampleData;
    w_sampleChNext    = r_sampleCh;
    w_sampleValidNext = 1'b0;
    w_frameNext       = r_frame;
    w_frameDoneNext   = 1'b0;
    w_shadowWe        = 1'b0;
    w_shadowClear     = 1'b0;
    w_cntClear        = 1'b0;
    w_cntTick         = 1'b0;

    case (r_state)
      IDLE: begin
        w_selNext  = '0;
        w_cntClear = 1'b1;
        if (bus.en) begin
          if (bus.manual) begin
            w_stateNext = MAN;
            w_selNext   = bus.man_sel;
          end else begin
            w_stateNext = SCAN;
          end
        end
      end

      SCAN: begin
        if (!bus.en) begin
          w_stateNext   = IDLE;
          w_selNext     = '0;
          w_cntClear    = 1'b1;
          w_shadowClear = 1'b1;
        end else if (bus.manual) begin
          w_stateNext   = MAN;
          w_selNext     = bus.man_sel;
          w_cntClear    = 1'b1;
          w_shadowClear = 1'b1;
        end else if (w_terminal) begin
          w_sampleDataNext  = bus.mux_out;
          w_sampleChNext    = r_sel;
          w_sampleValidNext = 1'b1;
          w_shadowWe        = 1'b1;
          w_cntTick         = 1'b1;
          w_selNext         = r_sel + 1'b1;
          if (r_sel == LAST_CH) begin
            w_frameNext     = {bus.mux_out, r_shadow[2], r_shadow[1], r_shadow[0]};
            w_frameDoneNext = 1'b1;
          end
        end else begin
          w_cntTick = 1'b1;
        end
      end

      MAN: begin
        w_selNext = bus.man_sel;
        if (!bus.en) begin
          w_stateNext = IDLE;
          w_selNext   = '0;
          w_cntClear  = 1'b1;
        end else if (!bus.manual) begin
          w_stateNext = SCAN;
          w_selNext   = '0;
          w_cntClear  = 1'b1;
        end else if (bus.man_sel != r_sel) begin
          w_cntClear = 1'b1;
        end else if (w_terminal) begin
          w_sampleDataNext  = bus.mux_out;
          w_sampleChNext    = r_sel;
          w_sampleValidNext = 1'b1;
          w_cntTick         = 1'b1;
        end else begin
          w_cntTick = 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_selNext   = '0;
        w_cntClear  = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Registered outputs; all of them clear immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel         <= '0;
      r_sampleData  <= '0;
      r_sampleCh    <= '0;
      r_sampleValid <= 1'b0;
      r_frame       <= '0;
      r_frameDone   <= 1'b0;
    end else begin
      r_sel         <= w_selNext;
      r_sampleData  <= w_sampleDataNext;
      r_sampleCh    <= w_sampleChNext;
      r_sampleValid <= w_sampleValidNext;
      r_frame       <= w_frameNext;
      r_frameDone   <= w_frameDoneNext;
    end
  end

  // Shadow registers for channels 0..2 of the frame being assembled.
  // Leaving SCAN throws the partial frame away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH - 1; i++) r_shadow[i] <= '0;
    end else if (w_shadowClear) begin
      for (int i = 0; i < N_CH - 1; i++) r_shadow[i] <= '0;
    end else if (w_shadowWe) begin
      for (int i = 0; i < N_CH - 1; i++) begin
        if (r_sel == SEL_W'(i)) r_shadow[i] <= bus.mux_out;
      end
    end
  end

  assign bus.sel          = r_sel;
  assign bus.sample_data  = r_sampleData;
  assign bus.sample_ch    = r_sampleCh;
  assign bus.sample_valid = r_sampleValid;
  assign bus.frame        = r_frame;
  assign bus.frame_done   = r_frameDone;
  assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sequencer
// Closes the loop through a 4:1 mux model (A,5,C,3) around two sequencers:
// dut (DWELL=4) and dut1 (DWELL=1). Directed vectors and hand sequences.
// ---------------------------------------------------------------------------
module tb_mux_scan_sequencer;
  import mux_scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] chIn [4];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  sel;
    logic        valid;
    logic [1:0]  ch;
    logic [3:0]  data;
    logic        done;
    logic [15:0] frame;
    logic        busy;
  } vec_t;

  vec_t scanVec [18];

  mux_scan_sequencer_if #(.DATA_WIDTH(4)) bus4 ();
  mux_scan_sequencer_if #(.DATA_WIDTH(4)) bus1 ();

  // The mux in the loop: purely combinational from each sequencer's sel.
  assign bus4.mux_out = chIn[bus4.sel];
  assign bus1.mux_out = chIn[bus1.sel];

  mux_scan_sequencer #(.DATA_WIDTH(4), .DWELL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4.master)
  );

  mux_scan_sequencer #(.DATA_WIDTH(4), .DWELL(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  always #5 clk = ~clk;

  // Hard stop so a stuck sequence can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic manual, input logic [1:0] manSel);
    bus4.en      = en;
    bus4.manual  = manual;
    bus4.man_sel = manSel;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_sel"},   32'(bus4.sel), 0);
    checkOutput({tag, "_data"},  32'(bus4.sample_data), 0);
    checkOutput({tag, "_ch"},    32'(bus4.sample_ch), 0);
    checkOutput({tag, "_valid"}, 32'(bus4.sample_valid), 0);
    checkOutput({tag, "_frame"}, 32'(bus4.frame), 0);
    checkOutput({tag, "_done"},  32'(bus4.frame_done), 0);
    checkOutput({tag, "_busy"},  32'(bus4.busy), 0);
  endtask

  // Counts edges (the enabling edge included) until frame_done, bounded.
  task automatic waitFrameDone(input string name, input int expectEdges);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < expectEdges + 8) begin
      @(posedge clk); #1;
      n++;
      seen = bus4.frame_done;
    end
    checkOutput({name, "_edges"}, seen ? n : 0, expectEdges);
    checkOutput({name, "_frame"}, 32'(bus4.frame), 32'h3C5A);
  endtask

  task automatic pulseReset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    int lastDone;
    int nDone;

    chIn[0] = 4'hA; chIn[1] = 4'h5; chIn[2] = 4'hC; chIn[3] = 4'h3;
    bus1.en = 1'b0; bus1.manual = 1'b0; bus1.man_sel = 2'd0;
    applyStimulus(1'b0, 1'b0, 2'd0);

    // Basic scan vectors, one row per edge starting with the enabling edge.
    scanVec[0]  = '{2'd0, 1'b0, 2'd0, 4'h0, 1'b0, 16'h0000, 1'b1};
    scanVec[1]  = '{2'd0, 1'b0, 2'd0, 4'h0, 1'b0, 16'h0000, 1'b1};
    scanVec[2]  = '{2'd0, 1'b0, 2'd0, 4'h0, 1'b0, 16'h0000, 1'b1};
    scanVec[3]  = '{2'd0, 1'b0, 2'd0, 4'h0, 1'b0, 16'h0000, 1'b1};
    scanVec[4]  = '{2'd1, 1'b1, 2'd0, 4'hA, 1'b0, 16'h0000, 1'b1};
    scanVec[5]  = '{2'd1, 1'b0, 2'd0, 4'hA, 1'b0, 16'h0000, 1'b1};
    scanVec[6]  = '{2'd1, 1'b0, 2'd0, 4'hA, 1'b0, 16'h0000, 1'b1};
    scanVec[7]  = '{2'd1, 1'b0, 2'd0, 4'hA, 1'b0, 16'h0000, 1'b1};
    scanVec[8]  = '{2'd2, 1'b1, 2'd1, 4'h5, 1'b0, 16'h0000, 1'b1};
    scanVec[9]  = '{2'd2, 1'b0, 2'd1, 4'h5, 1'b0, 16'h0000, 1'b1};
    scanVec[10] = '{2'd2, 1'b0, 2'd1, 4'h5, 1'b0, 16'h0000, 1'b1};
    scanVec[11] = '{2'd2, 1'b0, 2'd1, 4'h5, 1'b0, 16'h0000, 1'b1};
    scanVec[12] = '{2'd3, 1'b1, 2'd2, 4'hC, 1'b0, 16'h0000, 1'b1};
    scanVec[13] = '{2'd3, 1'b0, 2'd2, 4'hC, 1'b0, 16'h0000, 1'b1};
    scanVec[14] = '{2'd3, 1'b0, 2'd2, 4'hC, 1'b0, 16'h0000, 1'b1};
    scanVec[15] = '{2'd3, 1'b0, 2'd2, 4'hC, 1'b0, 16'h0000, 1'b1};
    scanVec[16] = '{2'd0, 1'b1, 2'd3, 4'h3, 1'b1, 16'h3C5A, 1'b1};
    scanVec[17] = '{2'd0, 1'b0, 2'd3, 4'h3, 1'b0, 16'h3C5A, 1'b1};

    // Reset state.
    #2 rst = 1'b1;
    #1;
    checkIdle("reset");
    checkOutput("reset_sel1", 32'(bus1.sel), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. Basic scan.
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("scan%0d_sel", i),   32'(bus4.sel),          32'(scanVec[i].sel));
      checkOutput($sformatf("scan%0d_valid", i), 32'(bus4.sample_valid), 32'(scanVec[i].valid));
      checkOutput($sformatf("scan%0d_ch", i),    32'(bus4.sample_ch),    32'(scanVec[i].ch));
      checkOutput($sformatf("scan%0d_data", i),  32'(bus4.sample_data),  32'(scanVec[i].data));
      checkOutput($sformatf("scan%0d_done", i),  32'(bus4.frame_done),   32'(scanVec[i].done));
      checkOutput($sformatf("scan%0d_frame", i), 32'(bus4.frame),        32'(scanVec[i].frame));
      checkOutput($sformatf("scan%0d_busy", i),  32'(bus4.busy),         32'(scanVec[i].busy));
    end

    // 2. Abort at E0+10, then restart.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 2'd0);
    repeat (10) @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    checkOutput("abort_busy",  32'(bus4.busy), 0);
    checkOutput("abort_sel",   32'(bus4.sel), 0);
    checkOutput("abort_frame", 32'(bus4.frame), 0);
    checkOutput("abort_ch",    32'(bus4.sample_ch), 1);
    checkOutput("abort_data",  32'(bus4.sample_data), 32'h5);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("abort_noCap%0d", k), 32'(bus4.sample_valid), 0);
    end
    applyStimulus(1'b1, 1'b0, 2'd0);
    waitFrameDone("abortRestart", 17);

    // 3. Asynchronous reset mid-frame, with a previous frame on the outputs.
    applyStimulus(1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2'd0);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkIdle("midReset");
    @(posedge clk); #1;
    rst = 1'b0;
    waitFrameDone("postReset", 17);

    // 4. Manual mode on channel 2, then switch to channel 1.
    applyStimulus(1'b0, 1'b0, 2'd0);
    pulseReset();
    applyStimulus(1'b1, 1'b1, 2'd2);
    @(posedge clk); #1;
    checkOutput("man_sel",  32'(bus4.sel), 2);
    checkOutput("man_busy", 32'(bus4.busy), 1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("man%0d_valid", k), 32'(bus4.sample_valid), (k % 4 == 0) ? 1 : 0);
      checkOutput($sformatf("man%0d_done", k),  32'(bus4.frame_done), 0);
      if (k % 4 == 0) begin
        checkOutput($sformatf("man%0d_ch", k),   32'(bus4.sample_ch), 2);
        checkOutput($sformatf("man%0d_data", k), 32'(bus4.sample_data), 32'hC);
      end
    end
    repeat (2) @(posedge clk);
    #1 applyStimulus(1'b1, 1'b1, 2'd1);
    @(posedge clk); #1;
    checkOutput("manSwitch_sel",   32'(bus4.sel), 1);
    checkOutput("manSwitch_valid", 32'(bus4.sample_valid), 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("manSw%0d_valid", k), 32'(bus4.sample_valid), (k == 4) ? 1 : 0);
    end
    checkOutput("manSw_ch",    32'(bus4.sample_ch), 1);
    checkOutput("manSw_data",  32'(bus4.sample_data), 32'h5);
    checkOutput("manSw_done",  32'(bus4.frame_done), 0);
    checkOutput("manSw_frame", 32'(bus4.frame), 0);
    applyStimulus(1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    checkOutput("manExit_busy", 32'(bus4.busy), 0);
    checkOutput("manExit_sel",  32'(bus4.sel), 0);

    // 5. DWELL=1: capture on every cycle, frame every fourth.
    pulseReset();
    bus1.en = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("d1_%0d_sel", k),   32'(bus1.sel), k % 4);
      checkOutput($sformatf("d1_%0d_valid", k), 32'(bus1.sample_valid), (k > 0) ? 1 : 0);
      checkOutput($sformatf("d1_%0d_done", k),  32'(bus1.frame_done), (k > 0 && k % 4 == 0) ? 1 : 0);
      checkOutput($sformatf("d1_%0d_frame", k), 32'(bus1.frame), (k >= 4) ? 32'h3C5A : 0);
      if (k > 0) begin
        checkOutput($sformatf("d1_%0d_ch", k),   32'(bus1.sample_ch), (k - 1) % 4);
        checkOutput($sformatf("d1_%0d_data", k), 32'(bus1.sample_data), 32'(chIn[(k - 1) % 4]));
      end
    end
    bus1.en = 1'b0;

    // 6. Three frames, channel 1 changes to 7 during frame 2.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 2'd0);
    lastDone = -1;
    nDone    = 0;
    for (int e = 1; e <= 52; e++) begin
      @(posedge clk); #1;
      if (bus4.frame_done) begin
        nDone++;
        checkOutput($sformatf("wrap_frame%0d", nDone), 32'(bus4.frame),
                    (nDone == 1) ? 32'h3C5A : 32'h3C7A);
        if (lastDone >= 0)
          checkOutput($sformatf("wrap_gap%0d", nDone), e - lastDone, 16);
        else
          checkOutput("wrap_first", e, 17);
        lastDone = e;
      end
      if (e == 17) chIn[1] = 4'h7;
    end
    checkOutput("wrap_count", nDone, 3);
    chIn[1] = 4'h5;
    applyStimulus(1'b0, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
